// File: rtl/ca_rule_stage.sv
// Elementary cellular-automaton stage: streams a row of 20-bit words through an external
// 22-bit shift window and emits the next generation. Define CA_GEN_COUNT_EN to add the row counter.
module ca_rule_stage #(
    parameter int ROW_WORDS = 32
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  rule,
    input  logic [19:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        shift_en,
    output logic [19:0] shift_din,
    input  logic [21:0] window,
    output logic [19:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        row_done,
    output logic [15:0] gen_count
);

    localparam int CW = $clog2(ROW_WORDS);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] LAST_WORD = CW'(ROW_WORDS - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] word_cnt_next;
    logic [7:0]    rule_q;
    logic [7:0]    rule_q_next;
    logic          pend;
    logic          pend_next;
    logic          pend_set;
    logic          first_win;
    logic          first_win_next;
    logic          capture;
    logic          allowed;
    logic          row_end;
    logic [21:0]   win_eff;

    // Bit i of the result looks up the rule with {left, centre, right} = window[i+2:i].
    function automatic logic [19:0] apply_rule(input logic [7:0] r, input logic [21:0] w);
        logic [19:0] res;
        res = 20'd0;
        for (int i = 0; i < 20; i++) begin
            res[i] = r[{w[i+2], w[i+1], w[i]}];
        end
        return res;
    endfunction

    assign capture = pend & (~out_valid | out_ready);
    assign allowed = ~pend | capture;
    // The left neighbour of a row's first word is whatever the buffer held before: force it to 0.
    assign win_eff = {window[21] & ~first_win, window[20:0]};

    // Next-state, shift-buffer control and input handshake.
    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        rule_q_next   = rule_q;
        in_ready      = 1'b0;
        shift_en      = 1'b0;
        shift_din     = 20'd0;
        pend_set      = 1'b0;
        row_end       = 1'b0;
        case (state)
            LOAD: begin
                in_ready  = allowed & ~clear;
                shift_en  = in_valid & allowed & ~clear;
                shift_din = in_data;
                if (shift_en) begin
                    word_cnt_next = word_cnt + CNT_ONE;
                    pend_set      = (word_cnt != CNT_ZERO);
                    if (word_cnt == CNT_ZERO) begin
                        rule_q_next = rule;
                    end else begin
                        rule_q_next = rule_q;
                    end
                    if (word_cnt == LAST_WORD) begin
                        state_next = FLUSH;
                    end else begin
                        state_next = LOAD;
                    end
                end else begin
                    word_cnt_next = word_cnt;
                end
            end
            FLUSH: begin
                shift_en = allowed & ~clear;
                pend_set = shift_en;
                if (shift_en) begin
                    state_next = DRAIN;
                end else begin
                    state_next = FLUSH;
                end
            end
            DRAIN: begin
                if (capture) begin
                    state_next    = LOAD;
                    word_cnt_next = CNT_ZERO;
                    row_end       = 1'b1;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Pending-word and first-window flags; a concurrent shift keeps pend set.
    always_comb begin
        if (pend_set) begin
            pend_next = 1'b1;
        end else if (capture) begin
            pend_next = 1'b0;
        end else begin
            pend_next = pend;
        end
        if (capture) begin
            first_win_next = row_end;
        end else begin
            first_win_next = first_win;
        end
    end

    // State registers and the registered output word.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= LOAD;
            word_cnt  <= CNT_ZERO;
            rule_q    <= 8'd0;
            pend      <= 1'b0;
            first_win <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 20'd0;
            row_done  <= 1'b0;
        end else begin
            state     <= state_next;
            word_cnt  <= word_cnt_next;
            rule_q    <= rule_q_next;
            pend      <= pend_next;
            first_win <= first_win_next;
            row_done  <= row_end;
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= apply_rule(rule_q, win_eff);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CA_GEN_COUNT_EN
    logic [15:0] gen_cnt;

    // Completed-row counter, wraps at 2^16.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            gen_cnt <= 16'd0;
        end else if (row_end) begin
            gen_cnt <= gen_cnt + 16'd1;
        end
    end

    assign gen_count = gen_cnt;
`else
    assign gen_count = 16'd0;
`endif

endmodule

// File: tb/tb_ca_rule_stage.sv
// Directed bench for ca_rule_stage: a 2-word instance for hand-computed rows and a 32-word
// instance for stall/clear scenarios; each DUT gets its own behavioural shift buffer.
module tb_ca_rule_stage;

    logic        clk = 1'b0;
    logic        clear;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic        sb_load;
    logic [7:0]  rule;
    logic [19:0] in_data;
    logic [59:0] sb_init;
    logic [59:0] sb_a;
    logic [59:0] sb_b;

    logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
    logic        in_ready_a, in_ready_b, shift_en_a, shift_en_b;
    logic        out_valid_a, out_valid_b, row_done_a, row_done_b;
    logic [19:0] shift_din_a, shift_din_b, out_data_a, out_data_b;
    logic [21:0] window_a, window_b;
    logic [15:0] gen_count_a, gen_count_b;
    logic        in_ready_m, shift_en_m, out_valid_m;
    logic [19:0] out_data_m;

    int n_checks = 0;
    int n_errors = 0;
    int rd_a = 0;
    int rd_b = 0;
    int rows_a = 0;
    int rows_b = 0;
    int got;
    int cyc;
    logic [19:0] row_in  [32];
    logic [19:0] row_out [32];
    logic [19:0] exp_out [32];

    always #5 clk = ~clk;

    assign in_valid_a  = in_valid & ~sel;
    assign in_valid_b  = in_valid & sel;
    assign out_ready_a = sel ? 1'b1 : out_ready;
    assign out_ready_b = sel ? out_ready : 1'b1;
    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign shift_en_m  = sel ? shift_en_b  : shift_en_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_data_m  = sel ? out_data_b  : out_data_a;

    // Shift buffer: prev word [59:40], centre [39:20], next [19:0].
    assign window_a = {sb_a[40], sb_a[39:20], sb_a[19]};
    assign window_b = {sb_b[40], sb_b[39:20], sb_b[19]};

    always @(posedge clk) begin
        if (sb_load) sb_a <= sb_init;
        else if (shift_en_a) sb_a <= {sb_a[39:0], shift_din_a};
    end

    always @(posedge clk) begin
        if (sb_load) sb_b <= sb_init;
        else if (shift_en_b) sb_b <= {sb_b[39:0], shift_din_b};
    end

    always @(posedge clk) begin
        if (row_done_a) rd_a <= rd_a + 1;
        if (row_done_b) rd_b <= rd_b + 1;
    end

    ca_rule_stage #(.ROW_WORDS(2)) dut_a (
        .clk(clk), .clear(clear), .rule(rule), .in_data(in_data),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .shift_en(shift_en_a), .shift_din(shift_din_a), .window(window_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .row_done(row_done_a), .gen_count(gen_count_a)
    );

    ca_rule_stage #(.ROW_WORDS(32)) dut_b (
        .clk(clk), .clear(clear), .rule(rule), .in_data(in_data),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .shift_en(shift_en_b), .shift_din(shift_din_b), .window(window_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .row_done(row_done_b), .gen_count(gen_count_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, want);
        end
    endtask

    function automatic logic [15:0] exp_gen(input int rows);
`ifndef CA_GEN_COUNT_EN
        rows = 0;
`endif
        return 16'(rows);
    endfunction

    // Reference: whole row as one bit string, zero outside the row.
    task automatic build_expected(input logic [7:0] r, input int n);
        logic       l, c, rt;
        logic [2:0] pat;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 20; i++) begin
                c = row_in[k][i];
                if (i < 19) l = row_in[k][i+1];
                else if (k > 0) l = row_in[k-1][0];
                else l = 1'b0;
                if (i > 0) rt = row_in[k][i-1];
                else if (k < n - 1) rt = row_in[k+1][19];
                else rt = 1'b0;
                pat = {l, c, rt};
                exp_out[k][i] = r[pat];
            end
        end
    endtask

    task automatic run_row(input bit which, input logic [7:0] r0, input logic [7:0] r1,
                           input int n, input int stall_at, input int stall_len, input int abort_at);
        int          idx;
        int          stall_left;
        bit          stalled;
        logic [19:0] held;
        idx = 0; got = 0; cyc = 0; stall_left = 0; stalled = 1'b0; held = 20'd0;
        for (int k = 0; k < 32; k++) row_out[k] = 20'hBADBA;
        sel = which;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                check("pre_clear_valid", out_valid_m, 1'b1);
                clear    = 1'b1;
                in_valid = 1'b1;
                in_data  = 20'h55555;
                #1;
                check("clear_in_ready", in_ready_m, 1'b0);
                check("clear_shift_en", shift_en_m, 1'b0);
                check("clear_out_valid", out_valid_m, 1'b0);
                check("clear_out_data", out_data_m, 20'd0);
                @(posedge clk);
                #1;
                check("clear_valid_edge", out_valid_m, 1'b0);
                @(negedge clk);
                clear    = 1'b0;
                in_valid = 1'b0;
                return;
            end
            rule = (idx == 0) ? r0 : r1;
            if (idx < n) begin
                in_valid = 1'b1;
                in_data  = row_in[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 20'd0;
            end
            if (stall_len > 0 && !stalled && got == stall_at) begin
                stalled    = 1'b1;
                stall_left = stall_len;
                held       = out_data_m;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("stall_in_ready", in_ready_m, 1'b0);
                check("stall_shift_en", shift_en_m, 1'b0);
                check("stall_hold", out_data_m, held);
                stall_left--;
            end
            if (in_valid && in_ready_m) idx++;
            if (out_valid_m && out_ready) begin
                row_out[got] = out_data_m;
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic row_test(input string tag, input bit which, input logic [7:0] r0,
                            input logic [7:0] r1, input int n, input int stall_at, input int stall_len);
        int rd0;
        rd0 = which ? rd_b : rd_a;
        run_row(which, r0, r1, n, stall_at, stall_len, -1);
        repeat (2) @(negedge clk);
        check({tag, "_count"}, got, n);
        check({tag, "_cycles"}, cyc, n + 3 + stall_len);
        for (int k = 0; k < n; k++) check($sformatf("%s_w%0d", tag, k), row_out[k], exp_out[k]);
        if (which) begin
            rows_b++;
            check({tag, "_row_done"}, rd_b - rd0, 1);
            check({tag, "_gen"}, gen_count_b, exp_gen(rows_b));
        end else begin
            rows_a++;
            check({tag, "_row_done"}, rd_a - rd0, 1);
            check({tag, "_gen"}, gen_count_a, exp_gen(rows_a));
        end
    endtask

    task automatic set2(input logic [19:0] i0, input logic [19:0] i1,
                        input logic [19:0] e0, input logic [19:0] e1);
        row_in[0] = i0; row_in[1] = i1;
        exp_out[0] = e0; exp_out[1] = e1;
    endtask

    task automatic preload_garbage();
        @(negedge clk);
        sb_init = 60'hFFFFFFFFFFFFFFF;
        sb_load = 1'b1;
        @(negedge clk);
        sb_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        rule = 8'd0; in_data = 20'hABCDE;
        sb_init = 60'hFFFFFFFFFFFFFFF; sb_load = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready_a", in_ready_a, 1'b0);
        check("rst_shift_en_a", shift_en_a, 1'b0);
        check("rst_out_valid_a", out_valid_a, 1'b0);
        check("rst_out_data_a", out_data_a, 20'd0);
        check("rst_row_done_a", row_done_a, 1'b0);
        check("rst_gen_a", gen_count_a, 16'd0);
        sel = 1'b1;
        #1;
        check("rst_in_ready_b", in_ready_b, 1'b0);
        check("rst_shift_en_b", shift_en_b, 1'b0);
        check("rst_out_valid_b", out_valid_b, 1'b0);
        check("rst_gen_b", gen_count_b, 16'd0);
        @(negedge clk);
        clear = 1'b0; sb_load = 1'b0; in_valid = 1'b0; sel = 1'b0;

        set2(20'h00000, 20'h00400, 20'h00000, 20'h00A00);
        row_test("r90", 1'b0, 8'd90, 8'd90, 2, -1, 0);
        set2(20'h12345, 20'h6789A, 20'hFFFFF, 20'hFFFFF);
        row_test("r255", 1'b0, 8'hFF, 8'hFF, 2, -1, 0);
        set2(20'hFFFFF, 20'hFFFFF, 20'h00000, 20'h00000);
        row_test("r0", 1'b0, 8'h00, 8'h00, 2, -1, 0);
        set2(20'h00000, 20'h00000, 20'hFFFFF, 20'hFFFFF);
        row_test("r1_zero", 1'b0, 8'h01, 8'h01, 2, -1, 0);
        set2(20'h80001, 20'h00000, 20'hC0003, 20'h80000);
        row_test("r30", 1'b0, 8'h1E, 8'h1E, 2, -1, 0);
        set2(20'h00000, 20'h00000, 20'hFFFFF, 20'hFFFFF);
        row_test("rule_mid_row", 1'b0, 8'hFF, 8'h00, 2, -1, 0);
        set2(20'h00000, 20'h00000, 20'h00000, 20'h00000);
        row_test("rule_next_row", 1'b0, 8'h00, 8'h00, 2, -1, 0);
        set2(20'h00000, 20'hFFFFF, 20'h00000, 20'h00000);
        row_test("prior_row", 1'b0, 8'h10, 8'h10, 2, -1, 0);
        preload_garbage();
        set2(20'h00000, 20'h00000, 20'h00000, 20'h00000);
        row_test("left_edge", 1'b0, 8'h10, 8'h10, 2, -1, 0);

        for (int k = 0; k < 32; k++) row_in[k] = 20'($urandom);
        build_expected(8'h6E, 32);
        row_test("r110_stream", 1'b1, 8'h6E, 8'h6E, 32, -1, 0);
        for (int k = 0; k < 32; k++) row_in[k] = 20'($urandom);
        build_expected(8'h96, 32);
        row_test("r150_stall", 1'b1, 8'h96, 8'h96, 32, 10, 5);

        for (int k = 0; k < 32; k++) row_in[k] = 20'hFFFFF;
        run_row(1'b1, 8'h1E, 8'h1E, 32, -1, 0, 2);
        rows_a = 0;
        rows_b = 0;
        check("abort_gen_a", gen_count_a, 16'd0);
        check("abort_gen_b", gen_count_b, 16'd0);
        for (int k = 0; k < 32; k++) row_in[k] = 20'($urandom);
        row_in[0] = row_in[0] & 20'h3FFFF;
        build_expected(8'h1E, 32);
        row_test("after_clear", 1'b1, 8'h1E, 8'h1E, 32, -1, 0);
        set2(20'h00400, 20'h00000, 20'h00A00, 20'h00000);
        row_test("a_after_clear", 1'b0, 8'd90, 8'd90, 2, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ca_rule_stage.md
CA_RULE_STAGE -- requirements
Module: ca_rule_stage

Interface
REQ-001 Parameter: ROW_WORDS, 32, 20-bit words per automaton row (min 2).
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 rule  input  8  Wolfram rule number, latched per row.
REQ-005 in_data  input  20  current-generation word from memory.
REQ-006 in_valid / in_ready  input / output  1 / 1  word handshake; transfer when both high.
REQ-007 shift_en  output  1  drives downstream-facing shift buffer shift_enable.
REQ-008 shift_din  output  20  drives shift buffer din.
REQ-009 window  input  22  shift buffer dout; [21] left neighbour, [20:1] centre cells, [0] right neighbour.
REQ-010 out_data / out_valid / out_ready  output / output / input  20 / 1 / 1  next-generation word handshake.
REQ-011 row_done  output  1  one-cycle pulse per completed row.
REQ-012 gen_count  output  16  completed-row counter.

Function
REQ-013 FSM states LOAD, FLUSH, DRAIN; shift_en asserts at most once per cycle.
REQ-014 pend flag = window centre holds an unemitted word; capture = pend & (!out_valid | out_ready); allowed = !pend | capture.
REQ-015 LOAD: in_ready = allowed; shift_en = in_valid & allowed; shift_din = in_data; word_cnt increments per transfer.
REQ-016 rule latched into rule_q on the first transfer of each row (word_cnt = 0).
REQ-017 Shift with word_cnt >= 1 (pre-increment) sets pend; pend clears on capture without a concurrent pend-setting shift.
REQ-018 Transfer of word ROW_WORDS-1 -> FLUSH; FLUSH: shift_en = allowed, shift_din = 0, pend set; on shift -> DRAIN.
REQ-019 DRAIN: no shifts, in_ready = 0; when capture occurs -> LOAD, word_cnt = 0, row_done pulses same cycle.
REQ-020 On capture, out_data[i] <= rule_q[{w[i+2], w[i+1], w[i]}], i = 0..19, w = window, except w[21] forced 0 for centre word 0 of a row (first_win flag).
REQ-021 Right boundary relies on FLUSH zero word; no masking of window[0].
REQ-022 out_valid set on capture; cleared on out_ready without capture; out_data stable while out_valid & !out_ready.
REQ-023 Throughput one word/cycle with out_ready held high; latency in_data transfer to out_valid = 2 cycles for word k < ROW_WORDS-1, last word emitted 1 cycle after FLUSH shift.
REQ-024 Stale shift buffer contents never reach out_data (first two shifts masked by REQ-017/REQ-020).
REQ-025 Row output count exactly ROW_WORDS; rule changes mid-row have no effect until next row.

Reset
REQ-026 clear asserted: state LOAD, word_cnt 0, pend 0, first_win 1, rule_q 0, out_valid 0, out_data 0, row_done 0, gen_count 0, shift_en 0, in_ready 0 while asserted.
REQ-027 Reset mid-row aborts row; partial output discarded; next row starts fresh from first in_data after deassert.

Configuration
REQ-028 Macro CA_GEN_COUNT_EN defined: gen_count increments (mod 2^16) on each row_done pulse.
REQ-029 CA_GEN_COUNT_EN undefined: gen_count tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-030 ROW_WORDS=2, rule 90, words 0x00000, 0x00400, out_ready=1 -> outputs 0x00000, 0x00A00; row_done one pulse.
REQ-031 rule 255, any two words -> out_data 0xFFFFF twice; rule 0 -> 0x00000; rule 0x01 with all-zero row -> 0xFFFFF (boundaries read 0).
REQ-032 Left-boundary: prior row ends 0xFFFFF, new row word0 0x00000, rule 0x10 -> out word0 bit19 = 0.
REQ-033 out_ready low 5 cycles mid-row -> in_ready low after one pend, no shift_en, out_data held; resume without loss or duplication.
REQ-034 clear pulsed after word 1 of 32 -> out_valid 0 next edge; following full row output matches reference model exactly.
REQ-035 With CA_GEN_COUNT_EN, 65537 rows -> gen_count 1; without, gen_count 0 throughout.
